// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx serial transmitter: state encoding,
// default word length and the counter-width helper.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 10;

  // Bits needed to count 0..value-1 (value >= 2 here, so the result is >= 1).
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'd1) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for piso_tx: counts 0..WIDTH-1 and flags the last bit.
// Saturates at WIDTH-1; wrapping back to zero happens only through clear.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] count_r;
  logic          last_s;

  assign last_s = (count_r == CW'(WIDTH - 1));
  assign count  = count_r;
  assign last   = last_s;

  // Counter register: clear has priority over enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable && !last_s) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and sends it MSB first, one bit per clock, marking the last bit.
module piso_tx
  import piso_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             data_out,
  output logic             out_valid,
  output logic             frame_done
);

  localparam int CW = clog2(WIDTH);

  state_e           state_r;
  state_e           state_next_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_next_s;
  logic             cnt_clear_s;
  logic             cnt_en_s;
  logic [CW-1:0]    count_s;
  logic [CW-1:0]    count_next_s;
  logic             last_s;
  logic             load_ready_s;
  logic             data_out_r;
  logic             out_valid_r;
  logic             frame_done_r;
  logic             data_out_next_s;
  logic             out_valid_next_s;
  logic             frame_done_next_s;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear_s),
    .enable (cnt_en_s),
    .count  (count_s),
    .last   (last_s)
  );

  // Next-state, shift-register and handshake decode.
  always_comb begin
    state_next_s = state_r;
    shreg_next_s = shreg_r;
    cnt_clear_s  = 1'b0;
    cnt_en_s     = 1'b0;
    load_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_ready_s = 1'b1;
        if (load_valid) begin
          shreg_next_s = load_data;
          cnt_clear_s  = 1'b1;
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shreg_next_s = {shreg_r[WIDTH-2:0], 1'b0};
        if (last_s) begin
          // Last bit on the line: a new word may follow with no gap.
          load_ready_s = 1'b1;
          cnt_clear_s  = 1'b1;
          if (load_valid) begin
            shreg_next_s = load_data;
            state_next_s = ST_SHIFT;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_clear_s  = 1'b1;
      end
    endcase
  end

  // Output values for the coming cycle, so the serial outputs can be registered.
  always_comb begin
    count_next_s = count_s;
    if (cnt_clear_s) begin
      count_next_s = {CW{1'b0}};
    end else if (cnt_en_s) begin
      count_next_s = count_s + CW'(1);
    end else begin
      count_next_s = count_s;
    end
    out_valid_next_s  = (state_next_s == ST_SHIFT);
    data_out_next_s   = out_valid_next_s ? shreg_next_s[WIDTH-1] : IDLE_LEVEL;
    frame_done_next_s = out_valid_next_s && (count_next_s == CW'(WIDTH - 1));
  end

  // State, shift register and registered serial outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      shreg_r      <= {WIDTH{1'b0}};
      data_out_r   <= IDLE_LEVEL;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      shreg_r      <= shreg_next_s;
      data_out_r   <= data_out_next_s;
      out_valid_r  <= out_valid_next_s;
      frame_done_r <= frame_done_next_s;
    end
  end

  assign load_ready = load_ready_s;
  assign data_out   = data_out_r;
  assign out_valid  = out_valid_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed scenarios plus random traffic,
// compared against a queue-of-bits model of the serial stream.
module tb_piso_tx;

  localparam int W = 10;

  logic         clk;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         data_out;
  logic         out_valid;
  logic         frame_done;

  int   vectors     = 0;
  int   miscompares = 0;

  // Model: bits still to appear on the line, front = bit shown this cycle.
  bit   exp_q[$];
  bit   cap_q[$];
  int   done_idx[$];
  logic [3:0] obs_s;
  logic [3:0] exp_s;

  piso_tx #(
    .WIDTH      (W),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs, sample DUT and model at the falling edge, advance at rising edge.
  task automatic tick(input logic lv, input logic [W-1:0] ld);
    logic acc;
    load_valid = lv;
    load_data  = ld;
    @(negedge clk);
    obs_s = {data_out, out_valid, frame_done, load_ready};
    exp_s = {(exp_q.size() != 0) ? exp_q[0] : 1'b0,
             exp_q.size() != 0, exp_q.size() == 1, exp_q.size() <= 1};
    if (out_valid) cap_q.push_back(data_out);
    if (frame_done) done_idx.push_back(cap_q.size());
    acc = lv && (exp_q.size() <= 1);
    @(posedge clk);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) for (int i = W - 1; i >= 0; i--) exp_q.push_back(ld[i]);
    #1;
  endtask

  function automatic logic [19:0] cap_vec();
    logic [19:0] v;
    v = 20'h0;
    foreach (cap_q[i]) v = {v[18:0], cap_q[i]};
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    return W'($urandom());
  endfunction

  task automatic test_reset();
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = rnd_word();
    #1;
    vectors++;
    if ({data_out, out_valid, frame_done, load_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_async: got %b want 0001", {data_out, out_valid, frame_done, load_ready});
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({data_out, out_valid, frame_done, load_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_with_load: got %b want 0001", {data_out, out_valid, frame_done, load_ready});
    end
    reset      = 1'b0;
    load_valid = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, rnd_word());
      vectors++;
      if (obs_s !== exp_s) begin
        miscompares++;
        $display("FAIL reset_idle c%0d: got %b want %b", c, obs_s, exp_s);
      end
    end
  endtask

  task automatic test_single_word();
    cap_q.delete();
    done_idx.delete();
    for (int c = 0; c < 13; c++) begin
      tick(c == 0, 10'h2E9);
      vectors++;
      if (obs_s !== exp_s) begin
        miscompares++;
        $display("FAIL single_word c%0d: got %b want %b", c, obs_s, exp_s);
      end
    end
    vectors++;
    if (cap_q.size() != 10 || cap_vec() !== 20'h002E9 || done_idx.size() != 1 || done_idx[0] != 10) begin
      miscompares++;
      $display("FAIL single_word_stream: got %0d bits %h done_cnt %0d want 10 bits 2e9 done at 10",
               cap_q.size(), cap_vec(), done_idx.size());
    end
  endtask

  task automatic test_back_to_back();
    cap_q.delete();
    done_idx.delete();
    for (int c = 0; c < 22; c++) begin
      tick(c <= 10, (c == 10) ? 10'h000 : 10'h3FF);
      vectors++;
      if (obs_s !== exp_s) begin
        miscompares++;
        $display("FAIL back_to_back c%0d: got %b want %b", c, obs_s, exp_s);
      end
    end
    vectors++;
    if (cap_q.size() != 20 || cap_vec() !== 20'hFFC00 || done_idx.size() != 2
        || done_idx[0] != 10 || done_idx[1] != 20) begin
      miscompares++;
      $display("FAIL back_to_back_stream: got %0d bits %h done_cnt %0d want 20 bits ffc00 done at 10,20",
               cap_q.size(), cap_vec(), done_idx.size());
    end
  endtask

  task automatic test_busy_ignore();
    cap_q.delete();
    done_idx.delete();
    for (int c = 0; c < 14; c++) begin
      tick((c == 0) || (c == 4), (c == 4) ? 10'h155 : 10'h2AA);
      vectors++;
      if (obs_s !== exp_s) begin
        miscompares++;
        $display("FAIL busy_ignore c%0d: got %b want %b", c, obs_s, exp_s);
      end
      if (c == 4) begin
        vectors++;
        if (obs_s[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_ready: got load_ready %b want 0", obs_s[0]);
        end
      end
    end
    vectors++;
    if (cap_q.size() != 10 || cap_vec() !== 20'h002AA) begin
      miscompares++;
      $display("FAIL busy_stream: got %0d bits %h want 10 bits 2aa", cap_q.size(), cap_vec());
    end
  endtask

  task automatic test_reset_mid_frame();
    cap_q.delete();
    for (int c = 0; c < 6; c++) begin
      tick(c == 0, 10'h3FF);
      vectors++;
      if (obs_s !== exp_s) begin
        miscompares++;
        $display("FAIL mid_reset_pre c%0d: got %b want %b", c, obs_s, exp_s);
      end
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({data_out, out_valid, frame_done, load_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL mid_reset_async: got %b want 0001", {data_out, out_valid, frame_done, load_ready});
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cap_q.delete();
    done_idx.delete();
    for (int c = 0; c < 12; c++) begin
      tick(c == 0, 10'h001);
      vectors++;
      if (obs_s !== exp_s) begin
        miscompares++;
        $display("FAIL mid_reset_post c%0d: got %b want %b", c, obs_s, exp_s);
      end
    end
    vectors++;
    if (cap_q.size() != 10 || cap_vec() !== 20'h00001) begin
      miscompares++;
      $display("FAIL mid_reset_stream: got %0d bits %h want 10 bits 001", cap_q.size(), cap_vec());
    end
  endtask

  task automatic test_load_stability();
    cap_q.delete();
    done_idx.delete();
    for (int c = 0; c < 12; c++) begin
      tick(c == 0, (c == 0) ? 10'h2C3 : rnd_word());
      vectors++;
      if (obs_s !== exp_s) begin
        miscompares++;
        $display("FAIL stability c%0d: got %b want %b", c, obs_s, exp_s);
      end
    end
    vectors++;
    if (cap_q.size() != 10 || cap_vec() !== 20'h002C3) begin
      miscompares++;
      $display("FAIL stability_stream: got %0d bits %h want 10 bits 2c3", cap_q.size(), cap_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick($urandom_range(0, 3) != 0, rnd_word());
      vectors++;
      if (obs_s !== exp_s) begin
        miscompares++;
        $display("FAIL random c%0d: got %b want %b", c, obs_s, exp_s);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_load_stability();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
